// File: rtl/sb_refill_if.sv
// Refill controller bus: cache miss handshake, stream-buffer probe/response,
// memory refill request/return, cache data-array fill port and statistics.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface sb_refill_if #(
    parameter int AW        = `ADDR_WIDTH - 2,
    parameter int DW        = `DATA_WIDTH,
    parameter int LINE_SIZE = 4,
    parameter int CNT_WIDTH = 16
);
    logic                           miss_req;
    logic [AW-1:0]                  miss_addr;
    logic                           sb_probe;
    logic [AW-1:0]                  sb_probe_addr;
    logic                           sb_hit;
    logic [LINE_SIZE-1:0][DW-1:0]   sb_rdata;
    logic                           mem_req;
    logic [AW-1:0]                  mem_req_addr;
    logic                           mem_line_valid;
    logic [LINE_SIZE-1:0][DW-1:0]   mem_line_data;
    logic                           fill_we;
    logic [AW-1:0]                  fill_addr;
    logic [DW-1:0]                  fill_wdata;
    logic                           miss_done;
    logic [CNT_WIDTH-1:0]           sb_hit_cnt;
    logic [CNT_WIDTH-1:0]           sb_miss_cnt;

    modport master (
        input  miss_req, miss_addr, sb_hit, sb_rdata, mem_line_valid, mem_line_data,
        output sb_probe, sb_probe_addr, mem_req, mem_req_addr, fill_we, fill_addr,
               fill_wdata, miss_done, sb_hit_cnt, sb_miss_cnt
    );

    modport slave (
        output miss_req, miss_addr, sb_hit, sb_rdata, mem_line_valid, mem_line_data,
        input  sb_probe, sb_probe_addr, mem_req, mem_req_addr, fill_we, fill_addr,
               fill_wdata, miss_done, sb_hit_cnt, sb_miss_cnt
    );
endinterface

// File: rtl/sb_refill_ctrl.sv
// D-cache refill controller: probes the stream buffer, falls back to memory,
// writes the line into the data array word by word and keeps hit/miss stats.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module sb_refill_ctrl #(
    parameter int BLOCK_OFFSET_WIDTH = 2,
    parameter int LINE_SIZE          = 2 ** BLOCK_OFFSET_WIDTH,
    parameter int CNT_WIDTH          = 16
) (
    input  logic          clk,
    input  logic          rst,
    sb_refill_if.master   bus
);
    localparam int AW  = `ADDR_WIDTH - 2;
    localparam int DW  = `DATA_WIDTH;
    localparam int BOW = BLOCK_OFFSET_WIDTH;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PROBE    = 3'd1;
    localparam logic [2:0] LOOKUP   = 3'd2;
    localparam logic [2:0] WAIT_MEM = 3'd3;
    localparam logic [2:0] WRITE    = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;

    localparam logic [BOW-1:0] K_LAST = BOW'(LINE_SIZE - 1);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
        if (cnt == {CNT_WIDTH{1'b1}}) begin
            return cnt;
        end else begin
            return cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    logic [2:0]                   state_r,  state_nxt_s;
    logic [AW-1:0]                addr_r,   addr_nxt_s;
    logic [LINE_SIZE-1:0][DW-1:0] line_r,   line_nxt_s;
    logic [BOW-1:0]               k_r,      k_nxt_s;
    logic                         hit_inc_s, miss_inc_s;
    logic [CNT_WIDTH-1:0]         hit_cnt_r, miss_cnt_r;

    logic                         sb_probe_r;
    logic                         mem_req_r;
    logic [AW-1:0]                mem_req_addr_r;
    logic                         fill_we_r;
    logic [AW-1:0]                fill_addr_r;
    logic [DW-1:0]                fill_wdata_r;
    logic                         miss_done_r;

    // Next-state, capture and statistic-increment decisions.
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        line_nxt_s  = line_r;
        k_nxt_s     = k_r;
        hit_inc_s   = 1'b0;
        miss_inc_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.miss_req) begin
                    addr_nxt_s  = bus.miss_addr;
                    state_nxt_s = PROBE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PROBE: begin
                state_nxt_s = LOOKUP;
            end
            LOOKUP: begin
                if (bus.sb_hit) begin
                    line_nxt_s  = bus.sb_rdata;
                    hit_inc_s   = 1'b1;
                    state_nxt_s = WRITE;
                end else begin
                    miss_inc_s  = 1'b1;
                    state_nxt_s = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                if (bus.mem_line_valid) begin
                    line_nxt_s  = bus.mem_line_data;
                    state_nxt_s = WRITE;
                end else begin
                    state_nxt_s = WAIT_MEM;
                end
            end
            WRITE: begin
                // k wraps back to zero naturally on the last word
                k_nxt_s = k_r + {{(BOW-1){1'b0}}, 1'b1};
                if (k_r == K_LAST) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WRITE;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                k_nxt_s     = {BOW{1'b0}};
            end
        endcase
    end

    // State, datapath and registered outputs derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            addr_r         <= {AW{1'b0}};
            line_r         <= {(LINE_SIZE*DW){1'b0}};
            k_r            <= {BOW{1'b0}};
            hit_cnt_r      <= {CNT_WIDTH{1'b0}};
            miss_cnt_r     <= {CNT_WIDTH{1'b0}};
            sb_probe_r     <= 1'b0;
            mem_req_r      <= 1'b0;
            mem_req_addr_r <= {AW{1'b0}};
            fill_we_r      <= 1'b0;
            fill_addr_r    <= {AW{1'b0}};
            fill_wdata_r   <= {DW{1'b0}};
            miss_done_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            addr_r     <= addr_nxt_s;
            line_r     <= line_nxt_s;
            k_r        <= k_nxt_s;
            if (hit_inc_s) begin
                hit_cnt_r <= sat_inc(hit_cnt_r);
            end
            if (miss_inc_s) begin
                miss_cnt_r <= sat_inc(miss_cnt_r);
            end
            sb_probe_r  <= (state_nxt_s == PROBE);
            miss_done_r <= (state_nxt_s == DONE);
            if (state_nxt_s == WAIT_MEM) begin
                mem_req_r      <= 1'b1;
                mem_req_addr_r <= {addr_nxt_s[AW-1:BOW], {BOW{1'b0}}};
            end else begin
                mem_req_r      <= 1'b0;
                mem_req_addr_r <= {AW{1'b0}};
            end
            if (state_nxt_s == WRITE) begin
                fill_we_r    <= 1'b1;
                fill_addr_r  <= {addr_nxt_s[AW-1:BOW], k_nxt_s};
                fill_wdata_r <= line_nxt_s[k_nxt_s];
            end else begin
                fill_we_r    <= 1'b0;
                fill_addr_r  <= {AW{1'b0}};
                fill_wdata_r <= {DW{1'b0}};
            end
        end
    end

    assign bus.sb_probe      = sb_probe_r;
    assign bus.sb_probe_addr = addr_r;
    assign bus.mem_req       = mem_req_r;
    assign bus.mem_req_addr  = mem_req_addr_r;
    assign bus.fill_we       = fill_we_r;
    assign bus.fill_addr     = fill_addr_r;
    assign bus.fill_wdata    = fill_wdata_r;
    assign bus.miss_done     = miss_done_r;
    assign bus.sb_hit_cnt    = hit_cnt_r;
    assign bus.sb_miss_cnt   = miss_cnt_r;

endmodule

// File: tb/tb_sb_refill_ctrl.sv
// Randomized bench for sb_refill_ctrl against a transaction-level timeline model.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_sb_refill_ctrl;
    localparam int AW     = `ADDR_WIDTH - 2;
    localparam int DW     = `DATA_WIDTH;
    localparam int LS     = 4;
    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   hit_m  = 0;
    int   miss_m = 0;

    sb_refill_if #(.LINE_SIZE(LS), .CNT_WIDTH(CW)) bus ();

    sb_refill_ctrl #(.BLOCK_OFFSET_WIDTH(2), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic stray();
        bus.sb_hit         = 1'($urandom_range(0, 1));
        bus.mem_line_valid = 1'($urandom_range(0, 1));
        for (int k = 0; k < LS; k++) begin
            bus.sb_rdata[k]      = $urandom;
            bus.mem_line_data[k] = $urandom;
        end
    endtask

    task automatic quiet(input string tag);
        check({tag, "_probe"}, bus.sb_probe, 1'b0);
        check({tag, "_memreq"}, bus.mem_req, 1'b0);
        check({tag, "_fillwe"}, bus.fill_we, 1'b0);
        check({tag, "_done"}, bus.miss_done, 1'b0);
        check({tag, "_hitcnt"}, bus.sb_hit_cnt, hit_m);
        check({tag, "_misscnt"}, bus.sb_miss_cnt, miss_m);
    endtask

    task automatic idle_cycles(input int n);
        bus.miss_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            quiet("idle");
            stray();
        end
    endtask

    // One complete miss: probe, lookup, optional memory wait, line write, done, idle.
    task automatic do_miss(input logic [AW-1:0] a, input bit hit, input int dly, input bit keep);
        logic [LS-1:0][DW-1:0] ln;
        logic [AW-1:0]         base;
        base = a & ~AW'(LS - 1);
        for (int k = 0; k < LS; k++) ln[k] = $urandom;
        bus.miss_req  = 1'b1;
        bus.miss_addr = a;
        @(negedge clk);
        check("probe", bus.sb_probe, 1'b1);
        check("probe_addr", bus.sb_probe_addr, a);
        check("probe_fillwe", bus.fill_we, 1'b0);
        stray();
        @(negedge clk);
        check("lookup_probe", bus.sb_probe, 1'b0);
        check("lookup_fillwe", bus.fill_we, 1'b0);
        check("lookup_memreq", bus.mem_req, 1'b0);
        bus.sb_hit         = hit;
        bus.sb_rdata       = hit ? ln : {LS{DW'($urandom)}};
        bus.mem_line_valid = 1'b0;
        if (!hit) begin
            for (int d = 0; d < dly; d++) begin
                @(negedge clk);
                check("wait_memreq", bus.mem_req, 1'b1);
                check("wait_memaddr", bus.mem_req_addr, base);
                check("wait_fillwe", bus.fill_we, 1'b0);
                stray();
                bus.mem_line_valid = (d == dly - 1);
                bus.mem_line_data  = (d == dly - 1) ? ln : {LS{DW'($urandom)}};
            end
        end
        for (int k = 0; k < LS; k++) begin
            @(negedge clk);
            check("write_we", bus.fill_we, 1'b1);
            check("write_addr", bus.fill_addr, AW'(base + AW'(k)));
            check("write_data", bus.fill_wdata, ln[k]);
            check("write_memreq", bus.mem_req, 1'b0);
            check("write_done", bus.miss_done, 1'b0);
            stray();
        end
        if (hit) hit_m = (hit_m < CNTMAX) ? hit_m + 1 : CNTMAX;
        else     miss_m = (miss_m < CNTMAX) ? miss_m + 1 : CNTMAX;
        @(negedge clk);
        check("done", bus.miss_done, 1'b1);
        check("done_fillwe", bus.fill_we, 1'b0);
        check("done_hitcnt", bus.sb_hit_cnt, hit_m);
        check("done_misscnt", bus.sb_miss_cnt, miss_m);
        bus.miss_req = keep;
        stray();
        @(negedge clk);
        quiet("post_done");
        stray();
    endtask

    initial begin
        logic [AW-1:0] a;
        bit            keep;
        rst                = 1'b1;
        bus.miss_req       = 1'b0;
        bus.miss_addr      = '0;
        bus.sb_hit         = 1'b0;
        bus.sb_rdata       = '0;
        bus.mem_line_valid = 1'b0;
        bus.mem_line_data  = '0;
        repeat (3) @(negedge clk);
        quiet("reset");
        check("reset_probe_addr", bus.sb_probe_addr, 0);
        check("reset_memaddr", bus.mem_req_addr, 0);
        check("reset_fill_addr", bus.fill_addr, 0);
        check("reset_fill_data", bus.fill_wdata, 0);
        rst = 1'b0;
        idle_cycles(3);

        do_miss(AW'(14'h104), 1'b1, 0, 1'b0);
        idle_cycles(1);
        do_miss(AW'(14'h20B), 1'b0, 10, 1'b0);
        idle_cycles(4);

        // Abort during the second WRITE cycle.
        bus.miss_req  = 1'b1;
        bus.miss_addr = AW'(14'h155);
        @(negedge clk);
        check("rst_probe", bus.sb_probe, 1'b1);
        bus.sb_hit = 1'b0;
        bus.mem_line_valid = 1'b0;
        @(negedge clk);
        bus.sb_hit = 1'b1;
        @(negedge clk);
        check("rst_w0", bus.fill_we, 1'b1);
        @(negedge clk);
        check("rst_w1", bus.fill_we, 1'b1);
        check("rst_w1_addr", bus.fill_addr, AW'(14'h155));
        rst = 1'b1;
        bus.miss_req = 1'b0;
        @(negedge clk);
        hit_m  = 0;
        miss_m = 0;
        quiet("after_rst");
        check("after_rst_probe_addr", bus.sb_probe_addr, 0);
        check("after_rst_fill_addr", bus.fill_addr, 0);
        rst = 1'b0;
        idle_cycles(2);
        do_miss(AW'($urandom), 1'b1, 0, 1'b0);
        idle_cycles(1);

        // Saturating hit counter with miss_req held across consecutive completions.
        a = AW'(14'h3F2);
        for (int i = 0; i < CNTMAX + 3; i++) do_miss(a, 1'b1, 0, i < CNTMAX + 2);
        a = AW'($urandom);
        do_miss(a, 1'b0, 3, 1'b1);
        do_miss(a, 1'b0, 1, 1'b0);
        idle_cycles(2);

        keep = 1'b0;
        a    = AW'($urandom);
        for (int i = 0; i < 60; i++) begin
            if (!keep) a = AW'($urandom);
            keep = 1'($urandom_range(0, 3) == 0);
            do_miss(a, 1'($urandom_range(0, 1)), $urandom_range(1, 12), keep);
            if (!keep) idle_cycles($urandom_range(0, 3));
        end
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sb_refill_ctrl.md
Name: sb_refill_ctrl

Overview:
Data-cache refill controller directly downstream of the stream-buffer group. On a D-cache miss it probes the stream buffer. On a hit it takes the buffered line. On a miss it requests the line from the memory refill path. Either way it writes the line into the cache data array one word per cycle, then signals completion to the cache. It also keeps saturating hit/miss statistics for prefetch tuning.

Parameters:
BLOCK_OFFSET_WIDTH, 2, word-offset bits per line; LINE_SIZE = 2**BLOCK_OFFSET_WIDTH.
LINE_SIZE, 4, words per cache line.
CNT_WIDTH, 16, width of hit/miss statistic counters.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
miss_req  in  1  cache miss pending; level, held until miss_done.
miss_addr  in  `ADDR_WIDTH-2  word address of the missing access; stable while miss_req is high.
sb_probe  out  1  to stream buffer cache_miss and miss_valid; one-cycle probe pulse.
sb_probe_addr  out  `ADDR_WIDTH-2  to stream buffer current_addr; the latched miss address.
sb_hit  in  1  from stream buffer hit_out.
sb_rdata  in  `DATA_WIDTH x LINE_SIZE  from stream buffer line data.
mem_req  out  1  line request to the memory refill path.
mem_req_addr  out  `ADDR_WIDTH-2  line-aligned word address (offset bits zero).
mem_line_valid  in  1  memory line returned; single-cycle pulse.
mem_line_data  in  `DATA_WIDTH x LINE_SIZE  returned line.
fill_we  out  1  cache data-array write enable.
fill_addr  out  `ADDR_WIDTH-2  word address being written.
fill_wdata  out  `DATA_WIDTH  word being written.
miss_done  out  1  one-cycle completion pulse.
sb_hit_cnt  out  CNT_WIDTH  stream-buffer hits, saturating.
sb_miss_cnt  out  CNT_WIDTH  stream-buffer misses, saturating.

Behaviour:
- Reset: state is IDLE. All outputs are 0. The line register, latched address, word counter and both statistic counters are cleared.
- Reset mid-operation: abort in the same edge, with no partial miss_done. Any fill words already written remain in the cache. The cache re-issues the miss.
- FSM states: IDLE, PROBE, LOOKUP, WAIT_MEM, WRITE, DONE.
- IDLE: on an edge with miss_req=1, latch miss_addr and go to PROBE. Otherwise stay.
- PROBE: sb_probe=1 for exactly one cycle; sb_probe_addr = latched address. Go to LOOKUP.
- LOOKUP: sample sb_hit.
  - sb_hit=1: capture sb_rdata into the line register, increment sb_hit_cnt, go to WRITE.
  - sb_hit=0: increment sb_miss_cnt, go to WAIT_MEM.
- WAIT_MEM: mem_req=1 and mem_req_addr = latched address with low BLOCK_OFFSET_WIDTH bits zeroed. Stay until mem_line_valid=1. On that edge, capture mem_line_data, drop mem_req on the next cycle, and go to WRITE.
- mem_line_valid in any other state is ignored.
- WRITE: lasts LINE_SIZE cycles. fill_we=1 every cycle.
  - Word counter k runs 0..LINE_SIZE-1.
  - fill_addr = {line base, k}; fill_wdata = line[k].
  - After k = LINE_SIZE-1, go to DONE. The counter wraps to 0.
- DONE: miss_done=1 for one cycle, then IDLE.
  - The requester deasserts miss_req in the cycle miss_done is high, so IDLE never re-accepts the same miss.
  - miss_req still high in IDLE after DONE is a new miss.
- Latency, stream-buffer hit: miss_req sampled at edge T gives PROBE T+1, LOOKUP T+2, WRITE T+3..T+2+LINE_SIZE, and miss_done at T+3+LINE_SIZE (T+7 for LINE_SIZE=4).
- Latency, stream-buffer miss: WRITE begins the cycle after mem_line_valid.
- Counters: increment by 1 and hold at 2**CNT_WIDTH-1 with no wrap. At most one counter increments per miss.
- Only one outstanding miss at a time; miss_req is ignored outside IDLE.
- fill_we is never high outside WRITE. sb_probe is never high outside PROBE.

Test Plan:
- Stream-buffer hit: miss_addr=0x104, sb_hit=1 in LOOKUP, sb_rdata={A0,A1,A2,A3} -> sb_probe pulse at T+1. fill writes (0x104,A0),(0x105,A1),(0x106,A2),(0x107,A3) at T+3..T+6 with base 0x104. miss_done at T+7. sb_hit_cnt=1.
- Stream-buffer miss: miss_addr=0x20B, sb_hit=0; mem_line_valid 10 cycles later with {B0..B3} -> mem_req high with mem_req_addr=0x208 until the valid edge. Writes 0x208..0x20B = B0..B3. miss_done once. sb_miss_cnt=1, sb_hit_cnt=0.
- Stray inputs: mem_line_valid pulsed in IDLE and in WRITE, and sb_hit=1 outside LOOKUP -> no state change, no extra writes, counters unchanged.
- Reset mid-operation: rst asserted during the second WRITE cycle -> next cycle all outputs 0, state IDLE, counters 0. A new miss afterwards completes normally.
- Saturation: preload by driving 65535 hits (or force CNT_WIDTH=4 and drive 16) -> sb_hit_cnt holds at all-ones.
- Back-to-back: miss_req kept high across miss_done -> a second probe is issued one cycle after DONE, and each miss produces exactly LINE_SIZE writes.
